cc_checker_multi: RTL

//  Parametrised N-channel MPEG-2 TS continuity-counter checker for the QoS monitor.

---
 rtl/cc_checker_multi_if.sv | 26 ++
 rtl/cc_checker_multi.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cc_checker_multi_if.sv
// Byte-stream and status bundle between the TS packet aligner, the
// multi-channel continuity-counter checker and the QoS register bank.
interface cc_checker_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  logic [8*N_CH-1:0]     r_data;
  logic [N_CH-1:0]       sync;
  logic [13*N_CH-1:0]    pid_sel;
  logic                  window_tick;
  logic [4*N_CH-1:0]     cc_expected;
  logic [N_CH-1:0]       locked;
  logic [N_CH-1:0]       cc_err;
  logic [N_CH-1:0]       sync_err;
  logic [CNT_W*N_CH-1:0] err_count;

  modport master (
    output r_data, sync, pid_sel, window_tick,
    input  cc_expected, locked, cc_err, sync_err, err_count
  );

  modport slave (
    input  r_data, sync, pid_sel, window_tick,
    output cc_expected, locked, cc_err, sync_err, err_count
  );
endinterface

// File: rtl/cc_checker_multi.sv
// N-channel MPEG-2 TS continuity-counter checker: per-channel header parser,
// CC tracking with single-duplicate tolerance and windowed saturating error counts.
module cc_checker_multi #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int PKT_LEN = 188
) (
  input logic               clk,
  input logic               rst,
  cc_checker_multi_if.slave bus
);

  localparam logic [2:0] ST_HUNT = 3'd0;
  localparam logic [2:0] ST_H1   = 3'd1;
  localparam logic [2:0] ST_H2   = 3'd2;
  localparam logic [2:0] ST_H3   = 3'd3;
  localparam logic [2:0] ST_PAY  = 3'd4;

  localparam logic [7:0] SYNC_BYTE = 8'h47;

  localparam int               BC_W     = $clog2(PKT_LEN);
  localparam logic [BC_W-1:0]  BC_FIRST = BC_W'(32'd4);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(PKT_LEN - 1);
  localparam logic [BC_W-1:0]  BC_ONE   = {{(BC_W-1){1'b0}}, 1'b1};

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [3:0] cc_inc(input logic [3:0] cc);
    return cc + 4'd1;
  endfunction

  function automatic logic [3:0] cc_dec(input logic [3:0] cc);
    return cc - 4'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic             inc);
    logic [CNT_W-1:0] res;
    if (inc && (cnt != CNT_MAX)) begin
      res = cnt + CNT_ONE;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [7:0]       byte_s;
    logic             sync_s;
    logic [12:0]      pid_sel_s;
    logic [3:0]       cc_s;
    logic             pid_hit_s;
    logic             has_payload_s;

    logic [2:0]       state_r;
    logic [2:0]       state_nx_s;
    logic [BC_W-1:0]  bcnt_r;
    logic [BC_W-1:0]  bcnt_nx_s;
    logic             hdr_done_s;
    logic             serr_nx_s;
    logic [4:0]       pid_hi_r;
    logic [7:0]       pid_lo_r;

    logic [3:0]       exp_r;
    logic [3:0]       exp_nx_s;
    logic             lock_r;
    logic             lock_nx_s;
    logic             dup_r;
    logic             dup_nx_s;
    logic             cc_err_r;
    logic             ccerr_nx_s;
    logic             sync_err_r;

    logic [CNT_W-1:0] run_r;
    logic [CNT_W-1:0] run_nx_s;
    logic [CNT_W-1:0] win_r;
    logic [CNT_W-1:0] win_nx_s;

    assign byte_s        = bus.r_data[8*i +: 8];
    assign sync_s        = bus.sync[i];
    assign pid_sel_s     = bus.pid_sel[13*i +: 13];
    assign cc_s          = byte_s[3:0];
    assign has_payload_s = byte_s[4];
    assign pid_hit_s     = ({pid_hi_r, pid_lo_r} == pid_sel_s);

    // Packet parser: a sync byte always wins over the current state.
    always_comb begin
      state_nx_s = state_r;
      bcnt_nx_s  = bcnt_r;
      hdr_done_s = 1'b0;
      serr_nx_s  = 1'b0;
      if (sync_s) begin
        if (byte_s == SYNC_BYTE) begin
          state_nx_s = ST_H1;
        end else begin
          state_nx_s = ST_HUNT;
          serr_nx_s  = 1'b1;
        end
      end else begin
        case (state_r)
          ST_HUNT: state_nx_s = ST_HUNT;
          ST_H1:   state_nx_s = ST_H2;
          ST_H2:   state_nx_s = ST_H3;
          ST_H3: begin
            state_nx_s = ST_PAY;
            bcnt_nx_s  = BC_FIRST;
            hdr_done_s = 1'b1;
          end
          ST_PAY: begin
            if (bcnt_r == BC_LAST) begin
              state_nx_s = ST_HUNT;
            end else begin
              bcnt_nx_s = bcnt_r + BC_ONE;
            end
          end
          default: state_nx_s = ST_HUNT;
        endcase
      end
    end

    // Parser state, byte counter and PID capture.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_r    <= ST_HUNT;
        bcnt_r     <= '0;
        pid_hi_r   <= 5'd0;
        pid_lo_r   <= 8'd0;
        sync_err_r <= 1'b0;
      end else begin
        state_r    <= state_nx_s;
        bcnt_r     <= bcnt_nx_s;
        sync_err_r <= serr_nx_s;
        if (!sync_s && (state_r == ST_H1)) begin
          pid_hi_r <= byte_s[4:0];
        end
        if (!sync_s && (state_r == ST_H2)) begin
          pid_lo_r <= byte_s;
        end
      end
    end

    // CC evaluation on a completed header carrying payload for the selected PID.
    always_comb begin
      exp_nx_s   = exp_r;
      lock_nx_s  = lock_r;
      dup_nx_s   = dup_r;
      ccerr_nx_s = 1'b0;
      if (hdr_done_s && pid_hit_s && has_payload_s) begin
        if (!lock_r) begin
          lock_nx_s = 1'b1;
          exp_nx_s  = cc_inc(cc_s);
        end else if (cc_s == exp_r) begin
          exp_nx_s = cc_inc(cc_s);
          dup_nx_s = 1'b0;
        end else if ((cc_s == cc_dec(exp_r)) && !dup_r) begin
          dup_nx_s = 1'b1;
        end else begin
          ccerr_nx_s = 1'b1;
          exp_nx_s   = cc_inc(cc_s);
          dup_nx_s   = 1'b0;
        end
      end else begin
        ccerr_nx_s = 1'b0;
      end
    end

    // The cc_err pulse on the output is the counted event, including on a tick cycle.
    always_comb begin
      if (bus.window_tick) begin
        win_nx_s = sat_add(run_r, cc_err_r);
        run_nx_s = '0;
      end else begin
        win_nx_s = win_r;
        run_nx_s = sat_add(run_r, cc_err_r);
      end
    end

    // CC tracking state, error pulse and window counters.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        exp_r    <= 4'd0;
        lock_r   <= 1'b0;
        dup_r    <= 1'b0;
        cc_err_r <= 1'b0;
        run_r    <= '0;
        win_r    <= '0;
      end else begin
        exp_r    <= exp_nx_s;
        lock_r   <= lock_nx_s;
        dup_r    <= dup_nx_s;
        cc_err_r <= ccerr_nx_s;
        run_r    <= run_nx_s;
        win_r    <= win_nx_s;
      end
    end

    assign bus.cc_expected[4*i +: 4]       = exp_r;
    assign bus.locked[i]                   = lock_r;
    assign bus.cc_err[i]                   = cc_err_r;
    assign bus.sync_err[i]                 = sync_err_r;
    assign bus.err_count[CNT_W*i +: CNT_W] = win_r;
  end

endmodule
